vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock. It drives the `hCount`/`vCount`/`bright` bus consumed by the board and sprite renderers, and the `hSync`/`vSync` pins. Pixel-domain work is qualified by a one-cycle `pix_tick` pulse, so no derived clock is used. It also gives game logic per-line and per-frame strobes.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/pixel_tick_gen.sv | 39 +++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Shared 640x480 @ 60 Hz raster constants and count type for the
//            timing generator and the renderers that consume its bus.
//            Renderers subtract c_vis_origin_x/y from hCount/vCount to get
//            screen-relative coordinates.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  typedef logic [COUNT_W-1:0] count_t;

  // Default divider: 100 MHz system clock down to a 25 MHz pixel rate
  localparam int c_clk_div     = 4;

  localparam int c_h_total     = 800;
  localparam int c_h_sync      = 96;
  localparam int c_h_vis_start = 144;
  localparam int c_h_vis_end   = 783;

  localparam int c_v_total     = 525;
  localparam int c_v_sync      = 2;
  localparam int c_v_vis_start = 35;
  localparam int c_v_vis_end   = 514;

  // Top-left corner of the visible area in raster coordinates
  localparam int c_vis_origin_x = c_h_vis_start;
  localparam int c_vis_origin_y = c_v_vis_start;

  // Inclusive window test shared by the decode logic
  function automatic logic in_window(count_t val, count_t lo, count_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Purpose  : Raster timing bus from the timing generator to the renderers.
// Ports    : hCount/vCount  - current column / line
//            bright         - inside the visible window
//            hSync/vSync    - active-low sync pins
//            pix_tick       - one-clk pulse when the counts take a new value
//            line_start     - one-clk pulse when hCount becomes 0
//            frame_start    - one-clk pulse when hCount and vCount become 0
//            master: timing generator side, slave: consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  count_t hCount;
  count_t vCount;
  logic   bright;
  logic   hSync;
  logic   vSync;
  logic   pix_tick;
  logic   line_start;
  logic   frame_start;

  modport master (
    output hCount, vCount, bright, hSync, vSync,
           pix_tick, line_start, frame_start
  );

  modport slave (
    input  hCount, vCount, bright, hSync, vSync,
           pix_tick, line_start, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pixel_tick_gen
// Purpose  : Free-running clock divider. o_advance is high combinationally
//            while the divider sits at CLK_DIV-1, so the consumer registers
//            its pixel update on the same edge that wraps the divider.
// Ports    : clk       - system clock
//            rst       - asynchronous, active-high reset
//            o_advance - pixel advance strobe, one clk in every CLK_DIV
// Revision : 1.0 - initial release
// ============================================================================
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  output logic      o_advance
);

  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  logic [c_div_w-1:0] r_div;

  assign o_advance = (r_div == c_div_last);

  // >= rather than == so an out-of-range divider value recovers on its own
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (r_div >= c_div_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_div_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 640x480 @ 60 Hz VGA raster timing generated from the system
//            clock with a pixel-rate enable instead of a derived clock.
// Ports    : clk - system clock (100 MHz)
//            rst - asynchronous, active-high reset
//            vga - timing bus (master): hCount, vCount, bright, hSync,
//                  vSync, pix_tick, line_start, frame_start
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = c_clk_div,
  parameter int H_TOTAL     = c_h_total,
  parameter int H_SYNC      = c_h_sync,
  parameter int H_VIS_START = c_h_vis_start,
  parameter int H_VIS_END   = c_h_vis_end,
  parameter int V_TOTAL     = c_v_total,
  parameter int V_SYNC      = c_v_sync,
  parameter int V_VIS_START = c_v_vis_start,
  parameter int V_VIS_END   = c_v_vis_end
) (
  input  wire logic        clk,
  input  wire logic        rst,
  vga_timing_gen_if.master vga
);

  localparam count_t c_h_last      = count_t'(H_TOTAL - 1);
  localparam count_t c_v_last      = count_t'(V_TOTAL - 1);
  localparam count_t c_h_sync_w    = count_t'(H_SYNC);
  localparam count_t c_v_sync_w    = count_t'(V_SYNC);
  localparam count_t c_h_vis_lo    = count_t'(H_VIS_START);
  localparam count_t c_h_vis_hi    = count_t'(H_VIS_END);
  localparam count_t c_v_vis_lo    = count_t'(V_VIS_START);
  localparam count_t c_v_vis_hi    = count_t'(V_VIS_END);

  logic   w_advance;
  logic   w_h_wrap;
  logic   w_v_wrap;
  count_t w_h_next;
  count_t w_v_next;

  count_t r_h_count;
  count_t r_v_count;
  logic   r_bright;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_pix_tick;
  logic   r_line_start;
  logic   r_frame_start;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .o_advance (w_advance)
  );

  // Wrap on an explicit compare; >= also pulls an illegal count back to 0
  assign w_h_wrap = (r_h_count >= c_h_last);
  assign w_v_wrap = (r_v_count >= c_v_last);

  always_comb begin
    w_h_next = r_h_count;
    w_v_next = r_v_count;
    if (w_advance) begin
      if (w_h_wrap) begin
        w_h_next = '0;
        w_v_next = w_v_wrap ? '0 : r_v_count + count_t'(1);
      end else begin
        w_h_next = r_h_count + count_t'(1);
      end
    end
  end

  // Decode from the next count values so sync/bright change on the same
  // edge as the counts they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_bright      <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_pix_tick    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_count     <= w_h_next;
      r_v_count     <= w_v_next;
      r_bright      <= in_window(w_h_next, c_h_vis_lo, c_h_vis_hi) &&
                       in_window(w_v_next, c_v_vis_lo, c_v_vis_hi);
      r_hsync       <= (w_h_next >= c_h_sync_w);
      r_vsync       <= (w_v_next >= c_v_sync_w);
      r_pix_tick    <= w_advance;
      r_line_start  <= w_advance && w_h_wrap;
      r_frame_start <= w_advance && w_h_wrap && w_v_wrap;
    end
  end

  assign vga.hCount      = r_h_count;
  assign vga.vCount      = r_v_count;
  assign vga.bright      = r_bright;
  assign vga.hSync       = r_hsync;
  assign vga.vSync       = r_vsync;
  assign vga.pix_tick    = r_pix_tick;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench. u_dut_d runs the default 640x480 timing
//            for the first lines; u_dut_s runs a shrunken raster (40x20
//            pixels, same divider) so whole frames fit in a short run.
//            Expected snapshots are queued per pixel tick and popped by a
//            monitor on each pix_tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vga_d ();
  vga_timing_gen_if vga_s ();

  vga_timing_gen u_dut_d (
    .clk (clk),
    .rst (rst),
    .vga (vga_d)
  );

  vga_timing_gen #(
    .CLK_DIV     (4),
    .H_TOTAL     (40),
    .H_SYNC      (6),
    .H_VIS_START (10),
    .H_VIS_END   (33),
    .V_TOTAL     (20),
    .V_SYNC      (2),
    .V_VIS_START (3),
    .V_VIS_END   (17)
  ) u_dut_s (
    .clk (clk),
    .rst (rst),
    .vga (vga_s)
  );

  typedef struct {
    int tick;
    int cyc;
    int h;
    int v;
    bit hs;
    bit vs;
    bit br;
    bit ls;
    bit fs;
  } exp_t;

  exp_t q_d[$];
  exp_t q_s[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc;
  int fs_cnt   = 0;
  int rgb_seen = 0;

  // Clock edges since reset release; tick n is due at edge 4*n
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic exp_t mk(int tick, int h, int v, bit hs, bit vs,
                              bit br, bit ls, bit fs);
    exp_t e;
    e.tick = tick; e.cyc = 4 * tick; e.h = h; e.v = v;
    e.hs = hs; e.vs = vs; e.br = br; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic cmp_entry(string tag, exp_t e, int h, int v, bit hs,
                           bit vs, bit br, bit ls, bit fs);
    string p;
    p = $sformatf("%s tick%0d", tag, e.tick);
    chk({p, " cycle"},       cyc, e.cyc);
    chk({p, " hCount"},      h,   e.h);
    chk({p, " vCount"},      v,   e.v);
    chk({p, " hSync"},       hs,  e.hs);
    chk({p, " vSync"},       vs,  e.vs);
    chk({p, " bright"},      br,  e.br);
    chk({p, " line_start"},  ls,  e.ls);
    chk({p, " frame_start"}, fs,  e.fs);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, " D hCount"},      vga_d.hCount,      0);
    chk({tag, " D vCount"},      vga_d.vCount,      0);
    chk({tag, " D hSync"},       vga_d.hSync,       0);
    chk({tag, " D vSync"},       vga_d.vSync,       0);
    chk({tag, " D bright"},      vga_d.bright,      0);
    chk({tag, " D pix_tick"},    vga_d.pix_tick,    0);
    chk({tag, " D line_start"},  vga_d.line_start,  0);
    chk({tag, " D frame_start"}, vga_d.frame_start, 0);
    chk({tag, " S hCount"},      vga_s.hCount,      0);
    chk({tag, " S vCount"},      vga_s.vCount,      0);
    chk({tag, " S hSync"},       vga_s.hSync,       0);
    chk({tag, " S vSync"},       vga_s.vSync,       0);
    chk({tag, " S pix_tick"},    vga_s.pix_tick,    0);
    chk({tag, " S frame_start"}, vga_s.frame_start, 0);
  endtask

  // Downstream renderer: solid block centred at (20,10) of the small raster
  logic [11:0] rgb;
  always_comb begin
    rgb = 12'h000;
    if (vga_s.bright && vga_s.hCount >= 14 && vga_s.hCount <= 26 &&
        vga_s.vCount >= 6 && vga_s.vCount <= 14)
      rgb = 12'hF80;
  end

  // Monitor for the default-timing DUT
  initial begin
    int tick = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tick = 0;
      end else begin
        if ((vga_d.line_start || vga_d.frame_start) && !vga_d.pix_tick)
          chk("D strobe without pix_tick", 1, 0);
        if (vga_d.pix_tick) begin
          tick++;
          if (q_d.size() > 0 && q_d[0].tick == tick) begin
            cmp_entry("D", q_d[0], vga_d.hCount, vga_d.vCount, vga_d.hSync,
                      vga_d.vSync, vga_d.bright, vga_d.line_start,
                      vga_d.frame_start);
            void'(q_d.pop_front());
          end
        end
      end
    end
  end

  // Monitor for the small-raster DUT, plus decode, frame period and render
  initial begin
    int tick    = 0;
    int last_fs = -1;
    int h;
    int v;
    forever begin
      @(negedge clk);
      if (rst) begin
        tick    = 0;
        last_fs = -1;
      end else begin
        if ((vga_s.line_start || vga_s.frame_start) && !vga_s.pix_tick)
          chk("S strobe without pix_tick", 1, 0);
        if (vga_s.frame_start) begin
          if (last_fs >= 0) chk("S frame period", cyc - last_fs, 3200);
          last_fs = cyc;
          fs_cnt++;
        end
        if (vga_s.pix_tick) begin
          tick++;
          h = int'(vga_s.hCount);
          v = int'(vga_s.vCount);
          chk("S hSync decode", vga_s.hSync, int'(h >= 6));
          chk("S vSync decode", vga_s.vSync, int'(v >= 2));
          chk("S bright decode", vga_s.bright,
              int'(h >= 10 && h <= 33 && v >= 3 && v <= 17));
          if (rgb != 12'h000) begin
            rgb_seen++;
            chk("S render outside active video",
                int'({vga_s.bright, vga_s.hSync, vga_s.vSync}), 7);
          end
          if (q_s.size() > 0 && q_s[0].tick == tick) begin
            cmp_entry("S", q_s[0], vga_s.hCount, vga_s.vCount, vga_s.hSync,
                      vga_s.vSync, vga_s.bright, vga_s.line_start,
                      vga_s.frame_start);
            void'(q_s.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_empty(int budget);
    int n = 0;
    while ((q_d.size() > 0 || q_s.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q_d.size() > 0 || q_s.size() > 0) begin
      chk("scoreboard drain timeout", q_d.size() + q_s.size(), 0);
      q_d.delete();
      q_s.delete();
    end
  endtask

  initial begin
    int n;

    // Reset release from power-up
    repeat (5) @(posedge clk);
    q_d.push_back(mk(   1,   1, 0, 0, 0, 0, 0, 0));
    q_d.push_back(mk(  95,  95, 0, 0, 0, 0, 0, 0));
    q_d.push_back(mk(  96,  96, 0, 1, 0, 0, 0, 0));
    q_d.push_back(mk( 143, 143, 0, 1, 0, 0, 0, 0));
    q_d.push_back(mk( 799, 799, 0, 1, 0, 0, 0, 0));
    q_d.push_back(mk( 800,   0, 1, 0, 0, 0, 1, 0));
    q_d.push_back(mk(1599, 799, 1, 1, 0, 0, 0, 0));
    q_d.push_back(mk(1600,   0, 2, 0, 1, 0, 1, 0));
    q_d.push_back(mk(1696,  96, 2, 1, 1, 0, 0, 0));

    q_s.push_back(mk(   1,  1,  0, 0, 0, 0, 0, 0));
    q_s.push_back(mk(   5,  5,  0, 0, 0, 0, 0, 0));
    q_s.push_back(mk(   6,  6,  0, 1, 0, 0, 0, 0));
    q_s.push_back(mk(  40,  0,  1, 0, 0, 0, 1, 0));
    q_s.push_back(mk( 100, 20,  2, 1, 1, 0, 0, 0));
    q_s.push_back(mk( 129,  9,  3, 1, 1, 0, 0, 0));
    q_s.push_back(mk( 130, 10,  3, 1, 1, 1, 0, 0));
    q_s.push_back(mk( 153, 33,  3, 1, 1, 1, 0, 0));
    q_s.push_back(mk( 154, 34,  3, 1, 1, 0, 0, 0));
    q_s.push_back(mk( 713, 33, 17, 1, 1, 1, 0, 0));
    q_s.push_back(mk( 730, 10, 18, 1, 1, 0, 0, 0));
    q_s.push_back(mk( 799, 39, 19, 1, 1, 0, 0, 0));
    q_s.push_back(mk( 800,  0,  0, 0, 0, 0, 1, 1));
    q_s.push_back(mk(1600,  0,  0, 0, 0, 0, 1, 1));
    q_s.push_back(mk(2400,  0,  0, 0, 0, 0, 1, 1));

    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset("release");
    wait_empty(12000);
    chk("S frame_start count over 3 frames", fs_cnt, 3);

    // Asynchronous reset in the middle of a frame
    n = 0;
    while (!(vga_s.hCount == 20 && vga_s.vCount == 10) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("reach S (20,10) before mid reset", int'(n < 4000), 1);
    #2 rst = 1'b1;
    #1 chk_reset("mid-frame reset");
    repeat (5) @(posedge clk);

    q_d.push_back(mk(  1,  1, 0, 0, 0, 0, 0, 0));
    q_d.push_back(mk( 96, 96, 0, 1, 0, 0, 0, 0));
    q_s.push_back(mk(  1,  1, 0, 0, 0, 0, 0, 0));
    q_s.push_back(mk( 40,  0, 1, 0, 0, 0, 1, 0));
    q_s.push_back(mk(800,  0, 0, 0, 0, 0, 1, 1));

    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset("re-release");
    wait_empty(4000);

    chk("renderer produced pixels", int'(rgb_seen > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
